rom_bcd_arbiter: RTL and testbench
==================================

Name: rom_bcd_arbiter

Overview:
Shares one synchronous ROM (registered address, 1-cycle read latency) between two requesters using round-robin arbitration. For each granted request it drives the ROM address, captures the data word, then converts it to 3-digit BCD with an iterative shift-add-3 engine, one bit per cycle. The result is returned with a valid/ready handshake tagged with the requester ID. It sits between the front-panel/display logic and the ROM block.

Parameters:
DATA_WIDTH, 8, ROM word width; only 8 is supported because the BCD output is fixed at 3 digits.
ADDR_WIDTH, 4, ROM address width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
req0  input  1  request from requester 0; level, held until ack0.
addr0  input  ADDR_WIDTH  ROM address for requester 0; stable while req0=1.
ack0  output  1  one-cycle pulse: request 0 accepted.
req1  input  1  request from requester 1.
addr1  input  ADDR_WIDTH  ROM address for requester 1.
ack1  output  1  one-cycle pulse: request 1 accepted.
rom_addr  output  ADDR_WIDTH  registered address to the ROM.
rom_data  input  DATA_WIDTH  ROM read data; valid 1 cycle after rom_addr changes.
resp_valid  output  1  response available.
resp_ready  input  1  consumer accepts response.
resp_id  output  1  requester that owns the response.
resp_addr  output  ADDR_WIDTH  address that was read.
resp_data  output  DATA_WIDTH  raw ROM word.
resp_bcd  output  12  BCD of resp_data: [11:8] hundreds, [7:4] tens, [3:0] units.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. On a rising edge with rst=1: state=IDLE; ack0=ack1=0; resp_valid=0; rom_addr, resp_id, resp_addr, resp_data and resp_bcd all 0; last_grant=1, so requester 0 wins the first tie.
- rst overrides everything, including mid-conversion and a pending response. An in-flight request is dropped with no response. Its ack has already been given, so the requester does not re-request automatically.
- FSM states:
  - IDLE: if req0 or req1 is high, grant one. Both high: grant the requester not equal to last_grant. On the grant edge: rom_addr<=addr_g, resp_id<=g, last_grant<=g, ack_g<=1 for the next cycle only, state->READ. No request: stay in IDLE.
  - READ (1 cycle): ack pulse visible. At the edge: resp_data<=rom_data, shift register<=rom_data, bcd accumulator<=0, bit counter<=0, state->CONV.
  - CONV (exactly 8 cycles), each edge:
    - first, add 3 to every 4-bit digit of the accumulator that is >=5;
    - then shift {acc, sreg} left by 1 so the MSB of sreg enters acc[0];
    - counter+1; when counter==7, state->DONE and resp_bcd<=final accumulator.
  - DONE: resp_valid=1, with resp_* stable. On an edge with resp_ready=1: resp_valid<=0, state->IDLE.
- resp_ready can be high before resp_valid; it is sampled only in DONE. resp_ready=1 while valid gives a single-cycle resp_valid.
- Requests are not accepted outside IDLE. A req held during busy is kept waiting, not lost, and is arbitrated when the block returns to IDLE.
- The earliest re-grant is the cycle after the DONE handshake edge, because IDLE evaluates requests then.
- Latency: grant edge E. ack high in cycle E+1. resp_valid first high in cycle E+10. Minimum per-transaction period is 11 cycles (grant, READ, 8×CONV, DONE).
- resp_addr<=rom_addr at the READ edge.
- Requesters deassert req the cycle after ack. A req still high when the block reaches IDLE is treated as a new request.
- Arithmetic: the accumulator is 12 bits; max input 255 gives 0x255, so there is no overflow. The digit adjust happens before each of the 8 shifts.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, no requests -> all outputs 0, busy=0, rom_addr=0.
2. Single request: ROM[3]=8'd255, req0 with addr0=3 -> ack0 pulses in cycle E+1, resp_valid in cycle E+10 with resp_id=0, resp_addr=3, resp_data=0xFF, resp_bcd=12'h255. Repeat with ROM[5]=8'd0 -> resp_bcd=12'h000; ROM[6]=8'd109 -> resp_bcd=12'h109.
3. Tie and round robin: req0 and req1 held continuously from reset, addr0=1 (ROM=8'd42), addr1=2 (ROM=8'd199), resp_ready=1 -> grant order 0,1,0,1; resp_bcd alternates 12'h042 and 12'h199; one response every 11 cycles.
4. Backpressure: resp_ready=0 for 20 cycles after resp_valid -> resp_valid and all resp_* stay stable, no new ack while req1 is pending; resp_ready=1 -> resp_valid drops, and ack1 pulses 2 cycles after the handshake edge.
5. Reset mid-conversion: assert rst in the 4th CONV cycle -> next cycle state IDLE, busy=0, resp_valid never asserts; next req0 is granted first because last_grant=1.
6. Late request: req1 raised during CONV of a req0 transaction -> no ack1 until the block returns to IDLE after the response handshake, then ack1, and the req1 response arrives 10 cycles after that grant.

Source files
------------

// File: rtl/rom_bcd_arbiter.sv
// rom_bcd_arbiter: round-robin sharing of one synchronous ROM between two
// requesters. Each granted read is converted to 3-digit BCD with a
// shift-add-3 engine, one bit per cycle, and is returned through a
// valid/ready handshake tagged with the requester ID.
module rom_bcd_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  ack1,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [11:0]           resp_bcd,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CONV,
        DONE
    } state_t;

    state_t                  state;
    logic                    last_grant;
    logic [DATA_WIDTH-1:0]   sreg;
    logic [11:0]             acc;
    logic [11:0]             acc_adj;
    logic [DATA_WIDTH+11:0]  shift_next;
    logic [2:0]              bit_cnt;
    logic                    grant_valid;
    logic                    grant_id;

    assign busy = (state != IDLE);

    // Pick a winner: a lone request wins outright, a tie goes to whoever did not win last time.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = 1'b0;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else if (req1) begin
            grant_id = 1'b1;
        end
    end

    // Digit correction before each shift, then the combined {acc, sreg} shifted left by one.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 3; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        shift_next = {acc_adj, sreg} << 1;
    end

    // Main controller: grant, ROM capture, 8-step conversion and response hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            resp_valid <= 1'b0;
            rom_addr   <= '0;
            resp_id    <= 1'b0;
            resp_addr  <= '0;
            resp_data  <= '0;
            resp_bcd   <= '0;
            last_grant <= 1'b1;
            sreg       <= '0;
            acc        <= '0;
            bit_cnt    <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        rom_addr   <= grant_id ? addr1 : addr0;
                        resp_id    <= grant_id;
                        last_grant <= grant_id;
                        ack0       <= ~grant_id;
                        ack1       <= grant_id;
                        state      <= READ;
                    end
                end
                READ: begin
                    resp_data <= rom_data;
                    resp_addr <= rom_addr;
                    sreg      <= rom_data;
                    acc       <= '0;
                    bit_cnt   <= '0;
                    state     <= CONV;
                end
                CONV: begin
                    acc     <= shift_next[DATA_WIDTH+11:DATA_WIDTH];
                    sreg    <= shift_next[DATA_WIDTH-1:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        resp_bcd   <= shift_next[DATA_WIDTH+11:DATA_WIDTH];
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_bcd_arbiter.sv
// tb_rom_bcd_arbiter: directed scenarios for the shared-ROM BCD arbiter.
module tb_rom_bcd_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          req0;
    logic          req1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic          ack0;
    logic          ack1;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_id;
    logic [AW-1:0] resp_addr;
    logic [DW-1:0] resp_data;
    logic [11:0]   resp_bcd;
    logic          busy;

    logic [DW-1:0] rom [16];
    int vectors;
    int miscompares;

    rom_bcd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .addr0      (addr0),
        .ack0       (ack0),
        .req1       (req1),
        .addr1      (addr1),
        .ack1       (ack1),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_addr  (resp_addr),
        .resp_data  (resp_data),
        .resp_bcd   (resp_bcd),
        .busy       (busy)
    );

    // ROM array is read through the DUT's registered address
    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ack0, ack1, resp_valid, busy} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl got %b expected 0000", {ack0, ack1, resp_valid, busy});
        end
        vectors++;
        if ({rom_addr, resp_id, resp_addr, resp_data, resp_bcd} !== 29'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_data got %h expected 0", {rom_addr, resp_id, resp_addr, resp_data, resp_bcd});
        end
        rst = 1'b0;
    endtask

    task automatic test_single(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [11:0] bcd);
        logic early;
        req0 = 1'b1; addr0 = a; resp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ack0, ack1, busy, rom_addr} !== {3'b101, a}) begin
            miscompares++;
            $display("[TB] FAIL single_ack got %b expected %b", {ack0, ack1, busy, rom_addr}, {3'b101, a});
        end
        req0 = 1'b0;
        early = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid || ack0 || ack1) early = 1'b1;
        end
        vectors++;
        if (early !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_early got %b expected 0", early);
        end
        @(negedge clk);
        vectors++;
        if ({resp_valid, resp_id, resp_addr, resp_data, resp_bcd} !== {1'b1, 1'b0, a, d, bcd}) begin
            miscompares++;
            $display("[TB] FAIL single_resp got %h expected %h",
                     {resp_valid, resp_id, resp_addr, resp_data, resp_bcd}, {1'b1, 1'b0, a, d, bcd});
        end
        @(negedge clk);
        vectors++;
        if ({resp_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL single_idle got %b expected 00", {resp_valid, busy});
        end
    endtask

    task automatic test_round_robin;
        logic          exp_id;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_d;
        logic [11:0]   exp_bcd;
        logic          early;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        addr0 = 4'd1; addr1 = 4'd2; resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            exp_id  = ((t % 2) == 1);
            exp_a   = exp_id ? 4'd2 : 4'd1;
            exp_d   = exp_id ? 8'd199 : 8'd42;
            exp_bcd = exp_id ? 12'h199 : 12'h042;
            @(negedge clk);
            vectors++;
            if ({ack0, ack1} !== {~exp_id, exp_id}) begin
                miscompares++;
                $display("[TB] FAIL rr_ack[%0d] got %b expected %b", t, {ack0, ack1}, {~exp_id, exp_id});
            end
            early = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (resp_valid || ack0 || ack1) early = 1'b1;
            end
            vectors++;
            if (early !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rr_busy_quiet[%0d] got %b expected 0", t, early);
            end
            @(negedge clk);
            vectors++;
            if ({resp_valid, resp_id, resp_addr, resp_data, resp_bcd} !== {1'b1, exp_id, exp_a, exp_d, exp_bcd}) begin
                miscompares++;
                $display("[TB] FAIL rr_resp[%0d] got %h expected %h", t,
                         {resp_valid, resp_id, resp_addr, resp_data, resp_bcd}, {1'b1, exp_id, exp_a, exp_d, exp_bcd});
            end
            @(negedge clk);
            vectors++;
            if ({resp_valid, busy, ack0, ack1} !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL rr_idle[%0d] got %b expected 0000", t, {resp_valid, busy, ack0, ack1});
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_backpressure;
        logic quiet;
        logic stable;
        req0 = 1'b1; addr0 = 4'd6; resp_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ack0, ack1} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL bp_ack0 got %b expected 10", {ack0, ack1});
        end
        req0 = 1'b0; req1 = 1'b1; addr1 = 4'd3;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (ack1) quiet = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if ({resp_valid, resp_id, resp_addr, resp_data, resp_bcd} !== {1'b1, 1'b0, 4'd6, 8'd109, 12'h109}) begin
            miscompares++;
            $display("[TB] FAIL bp_resp got %h expected %h",
                     {resp_valid, resp_id, resp_addr, resp_data, resp_bcd}, {1'b1, 1'b0, 4'd6, 8'd109, 12'h109});
        end
        stable = 1'b1;
        repeat (19) begin
            @(negedge clk);
            if ({resp_valid, resp_id, resp_addr, resp_data, resp_bcd} !== {1'b1, 1'b0, 4'd6, 8'd109, 12'h109}) stable = 1'b0;
            if (ack1) quiet = 1'b0;
        end
        vectors++;
        if ({stable, quiet} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL bp_hold got %b expected 11", {stable, quiet});
        end
        resp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({resp_valid, ack1, busy} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL bp_release got %b expected 000", {resp_valid, ack1, busy});
        end
        @(negedge clk);
        vectors++;
        if ({ack0, ack1, busy} !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL bp_ack1 got %b expected 011", {ack0, ack1, busy});
        end
        req1 = 1'b0;
        repeat (9) @(negedge clk);
        vectors++;
        if ({resp_valid, resp_id, resp_addr, resp_data, resp_bcd} !== {1'b1, 1'b1, 4'd3, 8'd255, 12'h255}) begin
            miscompares++;
            $display("[TB] FAIL bp_resp1 got %h expected %h",
                     {resp_valid, resp_id, resp_addr, resp_data, resp_bcd}, {1'b1, 1'b1, 4'd3, 8'd255, 12'h255});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_conv;
        logic early;
        req0 = 1'b1; addr0 = 4'd2; resp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ack0, ack1} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL rmc_ack0 got %b expected 10", {ack0, ack1});
        end
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if ({busy, resp_valid} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL rmc_conv got %b expected 10", {busy, resp_valid});
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, resp_valid, ack0, ack1, rom_addr, resp_bcd, resp_data} !== 28'd0) begin
            miscompares++;
            $display("[TB] FAIL rmc_cleared got %h expected 0", {busy, resp_valid, ack0, ack1, rom_addr, resp_bcd, resp_data});
        end
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 4'd5; addr1 = 4'd6;
        @(negedge clk);
        vectors++;
        if ({ack0, ack1, rom_addr} !== {2'b10, 4'd5}) begin
            miscompares++;
            $display("[TB] FAIL rmc_first_grant got %b expected %b", {ack0, ack1, rom_addr}, {2'b10, 4'd5});
        end
        req0 = 1'b0; req1 = 1'b0;
        early = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) early = 1'b1;
        end
        vectors++;
        if (early !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rmc_no_stale got %b expected 0", early);
        end
        @(negedge clk);
        vectors++;
        if ({resp_valid, resp_id, resp_addr, resp_data, resp_bcd} !== {1'b1, 1'b0, 4'd5, 8'd0, 12'h000}) begin
            miscompares++;
            $display("[TB] FAIL rmc_resp got %h expected %h",
                     {resp_valid, resp_id, resp_addr, resp_data, resp_bcd}, {1'b1, 1'b0, 4'd5, 8'd0, 12'h000});
        end
        @(negedge clk);
    endtask

    task automatic test_late_request;
        logic quiet;
        req0 = 1'b1; addr0 = 4'd1; resp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ack0, ack1} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL late_ack0 got %b expected 10", {ack0, ack1});
        end
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        req1 = 1'b1; addr1 = 4'd5;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (ack1) quiet = 1'b0;
        end
        vectors++;
        if ({resp_valid, resp_id, resp_addr, resp_data, resp_bcd} !== {1'b1, 1'b0, 4'd1, 8'd42, 12'h042}) begin
            miscompares++;
            $display("[TB] FAIL late_resp0 got %h expected %h",
                     {resp_valid, resp_id, resp_addr, resp_data, resp_bcd}, {1'b1, 1'b0, 4'd1, 8'd42, 12'h042});
        end
        @(negedge clk);
        if (ack1) quiet = 1'b0;
        vectors++;
        if ({quiet, resp_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL late_wait got %b expected 100", {quiet, resp_valid, busy});
        end
        @(negedge clk);
        vectors++;
        if ({ack0, ack1, rom_addr} !== {2'b01, 4'd5}) begin
            miscompares++;
            $display("[TB] FAIL late_ack1 got %b expected %b", {ack0, ack1, rom_addr}, {2'b01, 4'd5});
        end
        req1 = 1'b0;
        repeat (9) @(negedge clk);
        vectors++;
        if ({resp_valid, resp_id, resp_addr, resp_data, resp_bcd} !== {1'b1, 1'b1, 4'd5, 8'd0, 12'h000}) begin
            miscompares++;
            $display("[TB] FAIL late_resp1 got %h expected %h",
                     {resp_valid, resp_id, resp_addr, resp_data, resp_bcd}, {1'b1, 1'b1, 4'd5, 8'd0, 12'h000});
        end
        @(negedge clk);
    endtask

    // Scenario sequence followed by the summary line
    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 16; i++) rom[i] = 8'(i * 7 + 11);
        rom[1] = 8'd42;
        rom[2] = 8'd199;
        rom[3] = 8'd255;
        rom[5] = 8'd0;
        rom[6] = 8'd109;
        test_reset();
        test_single(4'd3, 8'd255, 12'h255);
        test_single(4'd5, 8'd0, 12'h000);
        test_single(4'd6, 8'd109, 12'h109);
        test_round_robin();
        test_backpressure();
        test_reset_mid_conv();
        test_late_request();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
